fetch_decode_unit: RTL
======================

// Module: fetch_decode_unit
// PURPOSE
//  Byte-serial instruction fetch/assemble/decode stage between program memory and execute.
//  - Consumes instruction bytes from a valid/ready stream.
//  - Assembles variable-length instructions (1-3 bytes) and decodes them.
//  - Holds the result in an output register until execute accepts it.
//  - Tracks the PC. Supports flush/redirect on a taken branch.
// PARAMETERS
//  DATA_W    16  datapath width of rhs (>=16)
//  ADDR_W    16  program counter width
//  BRANCH_W  11  signed branch offset field width (<=DATA_W, low bits of inst)
// PORTS
//  clk        in   1        clock, rising edge
//  rst_n      in   1        asynchronous active-low reset
//  flush      in   1        discard in-flight inst, redirect PC
//  flush_pc   in   ADDR_W   new PC on flush
//  in_valid   in   1        instruction byte available
//  in_data    in   8        instruction byte
//  in_ready   out  1        byte accepted when in_valid&in_ready
//  dec_valid  out  1        decoded instruction held
//  dec_ready  in   1        execute accepts when dec_valid&dec_ready
//  dec_op     out  4        op_t: NOP HALT LOAD STORE ADD SUB AND OR XOR NOT BRANCH IF OUTLO ILLEGAL
//  dec_src    out  2        src_t: NONE IMM RAM INDIRECT
//  dec_cond   out  2        IF cond: Z NZ ELSE NELSE (0 otherwise)
//  dec_use_acc out 1        rhs to be taken from accumulator (indirect load 0x44)
//  dec_rhs    out  DATA_W   operand
//  dec_len    out  2        bytes consumed (1..3)
//  dec_pc     out  ADDR_W   address of first byte
//  pc         out  ADDR_W   address of next byte to be consumed
// BEHAVIOUR
//  Reset:
//  - state=S_OP, pc=0, every dec_* output=0, dec_valid=0.
//  Stream handshake:
//  - in_ready=1 in S_OP/S_ARG/S_DATA, and also in S_OUT when dec_ready=1 (next opcode byte taken same cycle, zero-bubble).
//  - pc increments by 1 on every accepted byte, wrapping modulo 2^ADDR_W.
//  FSM:
//  - S_OP: latch opcode byte, dec_pc<=pc. Next state:
//    - op[7]=0 -> S_OUT
//    - op[7]=1 -> S_ARG
//  - S_ARG: latch arg byte. Next state:
//    - op[7:6]=2'b10 and src field op[2:1]==1 (data sources 2/3) -> S_DATA
//    - else -> S_OUT
//  - S_DATA: latch data byte -> S_OUT.
//  - S_OUT: dec_valid=1, all dec_* stable until accept.
//    - On accept with a concurrent byte -> S_ARG or S_OUT per the new opcode.
//    - On accept without a byte -> S_OP.
//  Decode (registered on entry to S_OUT, latency 1 clk after last byte):
//  - 1-byte op = opcode byte: 00 NOP, 01 HALT, 07 NOT, 08 OUTLO, 44 LOAD use_acc src=RAM.
//    Any other op[7]=0 value -> ILLEGAL.
//  - 2-byte op[7:3]: 10000 LOAD, 10001 ADD, 10010 STORE, 10011 SUB, 10100 AND, 10101 OR, 10110 XOR,
//    11000 BRANCH, 11110 IF; other -> ILLEGAL.
//  - src field op[2:0]:
//    - 0 -> rhs=zext(arg), src IMM
//    - 1 -> rhs=arg<<(DATA_W-8), src IMM
//    - 2 -> rhs=zext(data), src IMM
//    - 3 -> rhs=data<<(DATA_W-8), src IMM
//    - 4 -> rhs=zext(arg), src RAM
//    - 5 -> rhs=zext(arg), src INDIRECT
//    - 6/7 -> rhs=0, src NONE
//  - BRANCH: rhs=sext({op,arg}[BRANCH_W-1:0]) to DATA_W; src NONE.
//  - IF: {op[2:0],arg} 0x000 Z, 0x001 NZ, 0x010 ELSE, 0x011 NELSE; other -> ILLEGAL.
//  - ILLEGAL still outputs dec_len and dec_pc. Execute traps on it.
//  Flush (highest priority, any state, incl. same cycle as accept/byte):
//  - Next cycle: state=S_OP, dec_valid=0, pc=flush_pc.
//  - Byte offered in the flush cycle is not consumed: in_ready=0 during flush.
//  Reset mid-instruction: partial bytes discarded, nothing emitted.
// STRUCTURE
//  - Package cpu_pkg: op_t, src_t, cond_t enums; opcode constants (OP_NOP, OP_HALT, OP_NOT, OP_OUTLO, OP_LDIND, group codes); state_t.
//  - Sub-module decode_core: purely combinational, (opcode,arg,data) -> op/src/cond/rhs/len/use_acc.
//  - Top: FSM, byte registers, pc counter, output register.
// TESTING
//  - Reset, then stream 00 -> dec_valid after 1 clk, op NOP, len 1, dec_pc 0, pc 1.
//  - Stream 89 12 (ADD src1) -> op ADD, src IMM, rhs 0x1200, len 2.
//  - Stream 82 05 AB (LOAD src2) -> rhs 0x00AB, len 3; dec_ready held 0 for 5 clk -> outputs stable, in_ready 0.
//  - Stream C7 FE (BRANCH) -> rhs 0xFFFE; flush with flush_pc 0x0100 during S_ARG -> no dec_valid, pc 0x0100.
//  - Back-to-back 00,01,07 with dec_ready=1 -> one valid/clk after first, no bubbles, pc 3.
//  - F0 11 -> IF NELSE; F0 22 -> ILLEGAL len 2; pc FFFF + 1 byte -> pc wraps to 0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared types and opcode constants for the byte-serial fetch/decode stage.
// Included by the decode core and the fetch/decode top.
package cpu_pkg;

   typedef enum logic [3:0] {
      OPT_NOP, OPT_HALT, OPT_LOAD, OPT_STORE,
      OPT_ADD, OPT_SUB, OPT_AND, OPT_OR,
      OPT_XOR, OPT_NOT, OPT_BRANCH, OPT_IF,
      OPT_OUTLO, OPT_ILLEGAL
   } op_t;

   typedef enum logic [1:0] {
      SRC_NONE, SRC_IMM, SRC_RAM, SRC_IND
   } src_t;

   typedef enum logic [1:0] {
      C_Z, C_NZ, C_ELSE, C_NELSE
   } cond_t;

   typedef enum logic [1:0] {
      S_OP, S_ARG, S_DATA, S_OUT
   } state_t;

   localparam logic [7:0] OP_NOP   = 8'h00;
   localparam logic [7:0] OP_HALT  = 8'h01;
   localparam logic [7:0] OP_NOT   = 8'h07;
   localparam logic [7:0] OP_OUTLO = 8'h08;
   localparam logic [7:0] OP_LDIND = 8'h44;

   localparam logic [4:0] G_LOAD   = 5'b10000;
   localparam logic [4:0] G_ADD    = 5'b10001;
   localparam logic [4:0] G_STORE  = 5'b10010;
   localparam logic [4:0] G_SUB    = 5'b10011;
   localparam logic [4:0] G_AND    = 5'b10100;
   localparam logic [4:0] G_OR     = 5'b10101;
   localparam logic [4:0] G_XOR    = 5'b10110;
   localparam logic [4:0] G_BRANCH = 5'b11000;
   localparam logic [4:0] G_IF     = 5'b11110;

   // ALU-group opcodes with data sources 2/3 carry a third byte
   function automatic logic needs_data(input logic [7:0] op);
      return (op[7:6] == 2'b10) && (op[2:1] == 2'b01);
   endfunction

endpackage

// File: rtl/decode_core.sv
// Combinational decoder: (opcode, arg, data) bytes to decoded fields.
// Field meaning is independent of how the bytes were collected.
module decode_core
   import cpu_pkg::*;
#(
   parameter int DATA_W   = 16,
   parameter int BRANCH_W = 11
) (
   input  logic [7:0]        opc_i,
   input  logic [7:0]        arg_i,
   input  logic [7:0]        data_i,
   output op_t               op_o,
   output src_t              src_o,
   output cond_t             cond_o,
   output logic              use_acc_o,
   output logic [DATA_W-1:0] rhs_o,
   output logic [1:0]        len_o
);

   logic [10:0]       ifc;
   logic [DATA_W-1:0] srhs;
   src_t              ssrc;

   assign ifc = {opc_i[2:0], arg_i};

   always_comb begin
      ssrc = SRC_IMM;
      srhs = DATA_W'(arg_i);
      unique case (opc_i[2:0])
         3'd0: ;
         3'd1: srhs = DATA_W'(arg_i) << (DATA_W - 8);
         3'd2: srhs = DATA_W'(data_i);
         3'd3: srhs = DATA_W'(data_i) << (DATA_W - 8);
         3'd4: ssrc = SRC_RAM;
         3'd5: ssrc = SRC_IND;
         default: begin
            ssrc = SRC_NONE;
            srhs = '0;
         end
      endcase
   end

   always_comb begin
      op_o      = OPT_ILLEGAL;
      src_o     = SRC_NONE;
      cond_o    = C_Z;
      use_acc_o = 1'b0;
      rhs_o     = '0;
      len_o     = !opc_i[7] ? 2'd1 :
                  needs_data(opc_i) ? 2'd3 : 2'd2;
      if (!opc_i[7]) begin
         case (opc_i)
            OP_NOP:   op_o = OPT_NOP;
            OP_HALT:  op_o = OPT_HALT;
            OP_NOT:   op_o = OPT_NOT;
            OP_OUTLO: op_o = OPT_OUTLO;
            OP_LDIND: begin
               op_o      = OPT_LOAD;
               src_o     = SRC_RAM;
               use_acc_o = 1'b1;
            end
            default: ;
         endcase
      end else begin
         case (opc_i[7:3])
            G_LOAD:  op_o = OPT_LOAD;
            G_ADD:   op_o = OPT_ADD;
            G_STORE: op_o = OPT_STORE;
            G_SUB:   op_o = OPT_SUB;
            G_AND:   op_o = OPT_AND;
            G_OR:    op_o = OPT_OR;
            G_XOR:   op_o = OPT_XOR;
            G_BRANCH: begin
               op_o  = OPT_BRANCH;
               rhs_o = DATA_W'(signed'({opc_i[BRANCH_W-9:0], arg_i}));
            end
            G_IF: begin
               op_o = OPT_IF;
               case (ifc)
                  11'h000: cond_o = C_Z;
                  11'h001: cond_o = C_NZ;
                  11'h010: cond_o = C_ELSE;
                  11'h011: cond_o = C_NELSE;
                  default: op_o   = OPT_ILLEGAL;
               endcase
            end
            default: ;
         endcase
         if (!opc_i[6] && op_o != OPT_ILLEGAL) begin
            src_o = ssrc;
            rhs_o = srhs;
         end
      end
   end

endmodule

// File: rtl/fetch_decode_unit.sv
// Byte-serial fetch/assemble/decode stage with PC tracking and flush.
// Output register holds one decoded instruction until execute accepts it.
module fetch_decode_unit
   import cpu_pkg::*;
#(
   parameter int DATA_W   = 16,
   parameter int ADDR_W   = 16,
   parameter int BRANCH_W = 11
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic [ADDR_W-1:0] flush_pc,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   output logic              in_ready,
   output logic              dec_valid,
   input  logic              dec_ready,
   output op_t               dec_op,
   output src_t              dec_src,
   output cond_t             dec_cond,
   output logic              dec_use_acc,
   output logic [DATA_W-1:0] dec_rhs,
   output logic [1:0]        dec_len,
   output logic [ADDR_W-1:0] dec_pc,
   output logic [ADDR_W-1:0] pc
);

   state_t            state_q, state_d;
   logic [7:0]        op_q, arg_q;
   logic [ADDR_W-1:0] pc_q, ipc_q;
   logic              take, op_phase, fin;
   logic [7:0]        cop, carg;

   op_t               d_op;
   src_t              d_src;
   cond_t             d_cond;
   logic              d_acc;
   logic [DATA_W-1:0] d_rhs;
   logic [1:0]        d_len;

   assign in_ready = !flush && (state_q != S_OUT || dec_ready);
   assign take     = in_valid && in_ready;
   assign op_phase = (state_q == S_OP) || (state_q == S_OUT);
   assign cop      = op_phase ? in_data : op_q;
   assign carg     = (state_q == S_ARG) ? in_data : arg_q;
   assign pc       = pc_q;

   // Last byte of an instruction: decode result is registered this edge
   assign fin = take && ((op_phase && !in_data[7]) ||
                         (state_q == S_ARG && !needs_data(op_q)) ||
                         (state_q == S_DATA));

   decode_core #(
      .DATA_W   (DATA_W),
      .BRANCH_W (BRANCH_W)
   ) u_dec (
      .opc_i     (cop),
      .arg_i     (carg),
      .data_i    (in_data),
      .op_o      (d_op),
      .src_o     (d_src),
      .cond_o    (d_cond),
      .use_acc_o (d_acc),
      .rhs_o     (d_rhs),
      .len_o     (d_len)
   );

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_OP:   if (take) state_d = in_data[7] ? S_ARG : S_OUT;
         S_ARG:  if (take) state_d = needs_data(op_q) ? S_DATA : S_OUT;
         S_DATA: if (take) state_d = S_OUT;
         S_OUT: begin
            if (take)           state_d = in_data[7] ? S_ARG : S_OUT;
            else if (dec_ready) state_d = S_OP;
         end
         default: state_d = S_OP;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_OP;
         op_q        <= '0;
         arg_q       <= '0;
         pc_q        <= '0;
         ipc_q       <= '0;
         dec_valid   <= 1'b0;
         dec_op      <= OPT_NOP;
         dec_src     <= SRC_NONE;
         dec_cond    <= C_Z;
         dec_use_acc <= 1'b0;
         dec_rhs     <= '0;
         dec_len     <= '0;
         dec_pc      <= '0;
      end else if (flush) begin
         state_q   <= S_OP;
         dec_valid <= 1'b0;
         pc_q      <= flush_pc;
      end else begin
         state_q <= state_d;
         if (take) pc_q <= pc_q + 1'b1;
         if (take && op_phase) begin
            op_q  <= in_data;
            ipc_q <= pc_q;
         end
         if (take && state_q == S_ARG) arg_q <= in_data;
         if (fin) begin
            dec_valid   <= 1'b1;
            dec_op      <= d_op;
            dec_src     <= d_src;
            dec_cond    <= d_cond;
            dec_use_acc <= d_acc;
            dec_rhs     <= d_rhs;
            dec_len     <= d_len;
            dec_pc      <= op_phase ? pc_q : ipc_q;
         end else if (dec_valid && dec_ready) begin
            dec_valid <= 1'b0;
         end
      end
   end

endmodule
